// File: rtl/umi_mem_pkg.sv
// Shared UMI command-field layout, opcode/error codes and request classification
// for the UMI memory device.
package umi_mem_pkg;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

    localparam logic [1:0] UMI_ERR_OK     = 2'b00;
    localparam logic [1:0] UMI_ERR_SLVERR = 2'b10;
    localparam logic [1:0] UMI_ERR_DECERR = 2'b11;

    localparam int unsigned OPC_LSB  = 0;
    localparam int unsigned OPC_W    = 5;
    localparam int unsigned SIZE_LSB = 5;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned LEN_LSB  = 8;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned ERR_LSB  = 25;
    localparam int unsigned ERR_W    = 2;

    // Wide enough for the largest encodable transfer: 256 << 7 bytes.
    localparam int unsigned NB_W = 17;

    typedef enum logic [1:0] {
        KIND_READ,
        KIND_WRITE,
        KIND_POSTED,
        KIND_BAD
    } req_kind_e;

    function automatic logic [NB_W-1:0] umi_nb(input logic [2:0] size, input logic [7:0] len);
        return (NB_W'(len) + NB_W'(1)) << size;
    endfunction

    function automatic req_kind_e umi_kind(input logic [4:0] opc);
        case (opc)
            UMI_REQ_READ:   return KIND_READ;
            UMI_REQ_WRITE:  return KIND_WRITE;
            UMI_REQ_POSTED: return KIND_POSTED;
            default:        return KIND_BAD;
        endcase
    endfunction

endpackage

// File: rtl/umi_mem_dev_if.sv
// UMI device port pair: request channel into the device, response channel out of it.
interface umi_mem_dev_if #(
    parameter int unsigned DW = 256,
    parameter int unsigned AW = 64,
    parameter int unsigned CW = 32
);
    logic          req_valid;
    logic [CW-1:0] req_cmd;
    logic [AW-1:0] req_dstaddr;
    logic [AW-1:0] req_srcaddr;
    logic [DW-1:0] req_data;
    logic          req_ready;

    logic          resp_valid;
    logic [CW-1:0] resp_cmd;
    logic [AW-1:0] resp_dstaddr;
    logic [AW-1:0] resp_srcaddr;
    logic [DW-1:0] resp_data;
    logic          resp_ready;

    modport master (
        output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
    );

    modport slave (
        input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
        output req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
    );
endinterface

// File: rtl/umi_mem_resp_fifo.sv
// Synchronous response FIFO; a push into a full FIFO is taken when a pop
// happens in the same cycle.
module umi_mem_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    always_comb begin
        full     = (count_q == CNTW'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNTW'(do_push) - CNTW'(do_pop);
        count    = count_q;
        dout     = store[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/umi_mem_dev.sv
// Parametrised UMI memory device: byte-granular reads/writes into a synchronous RAM,
// one-cycle response stage, then a response FIFO toward the requester.
module umi_mem_dev
    import umi_mem_pkg::*;
#(
    parameter int unsigned DW         = 256,
    parameter int unsigned AW         = 64,
    parameter int unsigned CW         = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    umi_mem_dev_if.slave udev
);
    localparam int unsigned NBYTES = DW / 8;
    localparam int unsigned OFFW   = $clog2(NBYTES);
    localparam int unsigned WORDW  = $clog2(DEPTH);
    localparam int unsigned FW     = CW + 2 * AW + DW;
    localparam int unsigned CNTW   = $clog2(RESP_DEPTH + 1);
    localparam logic [AW-1:0] MEM_BYTES = AW'(DEPTH * NBYTES);

    logic [4:0]       req_opc;
    logic [2:0]       req_size;
    logic [7:0]       req_len;
    logic [NB_W-1:0]  req_nb;
    logic [OFFW-1:0]  req_off;
    logic [WORDW-1:0] req_word;
    logic             req_legal;
    req_kind_e        req_kind;

    logic [CNTW-1:0]  fifo_count;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [FW-1:0]    fifo_din, fifo_dout;
    logic             has_space, posted_ok, req_ready, accept, resp_valid;

    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     rd_word_q;
    logic [NBYTES-1:0] wr_be;
    logic [DW-1:0]     wr_data;
    logic              mem_we, mem_re;

    logic             stg_valid_q, stg_valid_d;
    logic [CW-1:0]    stg_cmd_q, stg_cmd_d;
    logic [AW-1:0]    stg_dst_q, stg_dst_d;
    logic [AW-1:0]    stg_src_q, stg_src_d;
    logic             stg_rd_q, stg_rd_d;
    logic [OFFW-1:0]  stg_off_q, stg_off_d;
    logic [NB_W-1:0]  stg_nb_q, stg_nb_d;
    logic [DW-1:0]    rd_shift, resp_data;

    always_comb begin
        req_opc   = udev.req_cmd[OPC_LSB +: OPC_W];
        req_size  = udev.req_cmd[SIZE_LSB +: SIZE_W];
        req_len   = udev.req_cmd[LEN_LSB +: LEN_W];
        req_nb    = umi_nb(req_size, req_len);
        req_off   = udev.req_dstaddr[OFFW-1:0];
        req_word  = udev.req_dstaddr[OFFW +: WORDW];
        req_kind  = umi_kind(req_opc);
        req_legal = (udev.req_dstaddr < MEM_BYTES)
                 && ((NB_W'(req_off) + req_nb) <= NB_W'(NBYTES))
                 && (req_nb <= NB_W'(NBYTES));
    end

    // Legal posted writes bypass the FIFO-space test; this term is decoded from the
    // request fields only, so valid still never reaches ready combinationally.
    always_comb begin
        has_space = !fifo_full && ((32'(fifo_count) + 32'(stg_valid_q)) < RESP_DEPTH);
        posted_ok = (req_kind == KIND_POSTED) && req_legal;
        req_ready = !rst && (has_space || posted_ok);
        accept    = udev.req_valid && req_ready;
    end

    always_comb begin
        mem_we  = accept && req_legal && (req_kind == KIND_WRITE || req_kind == KIND_POSTED);
        mem_re  = accept && req_legal && (req_kind == KIND_READ);
        wr_data = udev.req_data << {req_off, 3'b000};
        wr_be   = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            wr_be[i] = (NB_W'(i) >= NB_W'(req_off)) && (NB_W'(i) < NB_W'(req_off) + req_nb);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) mem[req_word][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        if (mem_re) rd_word_q <= mem[req_word];
    end

    always_comb begin
        stg_valid_d = accept && (req_kind != KIND_POSTED);
        stg_cmd_d   = '0;
        stg_cmd_d[OPC_LSB +: OPC_W]   = (req_kind == KIND_READ) ? UMI_RESP_READ : UMI_RESP_WRITE;
        stg_cmd_d[SIZE_LSB +: SIZE_W] = req_size;
        stg_cmd_d[LEN_LSB +: LEN_W]   = req_len;
        if (req_kind == KIND_BAD)
            stg_cmd_d[ERR_LSB +: ERR_W] = UMI_ERR_SLVERR;
        else if (!req_legal)
            stg_cmd_d[ERR_LSB +: ERR_W] = UMI_ERR_DECERR;
        stg_dst_d = udev.req_srcaddr;
        stg_src_d = udev.req_dstaddr;
        stg_rd_d  = (req_kind == KIND_READ) && req_legal;
        stg_off_d = req_off;
        stg_nb_d  = req_nb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_cmd_q   <= '0;
            stg_dst_q   <= '0;
            stg_src_q   <= '0;
            stg_rd_q    <= 1'b0;
            stg_off_q   <= '0;
            stg_nb_q    <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_cmd_q   <= stg_cmd_d;
            stg_dst_q   <= stg_dst_d;
            stg_src_q   <= stg_src_d;
            stg_rd_q    <= stg_rd_d;
            stg_off_q   <= stg_off_d;
            stg_nb_q    <= stg_nb_d;
        end
    end

    always_comb begin
        rd_shift  = rd_word_q >> {stg_off_q, 3'b000};
        resp_data = '0;
        if (stg_rd_q) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (NB_W'(i) < stg_nb_q) resp_data[i*8 +: 8] = rd_shift[i*8 +: 8];
            end
        end
    end

    assign fifo_din = {stg_cmd_q, stg_dst_q, stg_src_q, resp_data};

    umi_mem_resp_fifo #(
        .WIDTH (FW),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (stg_valid_q),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        resp_valid = !rst && !fifo_empty;
        fifo_pop   = resp_valid && udev.resp_ready;
    end

    assign udev.req_ready  = req_ready;
    assign udev.resp_valid = resp_valid;
    assign {udev.resp_cmd, udev.resp_dstaddr, udev.resp_srcaddr, udev.resp_data} =
        resp_valid ? fifo_dout : '0;

endmodule

// File: tb/tb_umi_mem_dev.sv
// Randomised scoreboard bench for umi_mem_dev against a byte-array memory model.
module tb_umi_mem_dev;
    localparam int unsigned DW         = 256;
    localparam int unsigned AW         = 64;
    localparam int unsigned CW         = 32;
    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned RESP_DEPTH = 4;
    localparam int unsigned NBYTES     = DW / 8;
    localparam int unsigned MEMB       = DEPTH * NBYTES;
    localparam int unsigned REGION_W   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    umi_mem_dev_if #(.DW(DW), .AW(AW), .CW(CW)) udev ();

    umi_mem_dev #(
        .DW         (DW),
        .AW         (AW),
        .CW         (CW),
        .DEPTH      (DEPTH),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .udev (udev)
    );

    typedef struct {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mem_m [MEMB];
    int         checks   = 0;
    int         failures = 0;
    int         ready_mode = 1;   // 0 hold low, 1 hold high, 2 random

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       udev.resp_ready = 1'b0;
            1:       udev.resp_ready = 1'b1;
            default: udev.resp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake and checks hold stability.
    bit            hold_pend = 1'b0;
    logic [CW-1:0] h_cmd;
    logic [AW-1:0] h_dst, h_src;
    logic [DW-1:0] h_data;
    exp_t          me;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                checks++;
                if (!udev.resp_valid || udev.resp_cmd !== h_cmd || udev.resp_dstaddr !== h_dst
                    || udev.resp_srcaddr !== h_src || udev.resp_data !== h_data) begin
                    failures++;
                    $display("FAIL resp_stable valid=%0b cmd=%h held_cmd=%h", udev.resp_valid, udev.resp_cmd, h_cmd);
                end
            end
            if (udev.resp_valid && udev.resp_ready) begin
                hold_pend = 1'b0;
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected got cmd=%h dst=%h", udev.resp_cmd, udev.resp_dstaddr);
                end else begin
                    me = expq.pop_front();
                    if (udev.resp_cmd !== me.cmd || udev.resp_dstaddr !== me.dst
                        || udev.resp_srcaddr !== me.src || udev.resp_data !== me.data) begin
                        failures++;
                        $display("FAIL resp_match got cmd=%h dst=%h src=%h data=%h exp cmd=%h dst=%h src=%h data=%h",
                                 udev.resp_cmd, udev.resp_dstaddr, udev.resp_srcaddr, udev.resp_data,
                                 me.cmd, me.dst, me.src, me.data);
                    end
                end
            end else if (udev.resp_valid) begin
                hold_pend = 1'b1;
                h_cmd  = udev.resp_cmd;
                h_dst  = udev.resp_dstaddr;
                h_src  = udev.resp_srcaddr;
                h_data = udev.resp_data;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    function automatic logic [CW-1:0] mk_cmd(input int opc, input int size, input int len);
        logic [CW-1:0] c;
        c        = '0;
        c[4:0]   = 5'(opc);
        c[7:5]   = 3'(size);
        c[15:8]  = 8'(len);
        return c;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    // Reference model: apply the request to the byte array and queue its response.
    task automatic model_accept(input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                                input logic [AW-1:0] src, input logic [DW-1:0] data);
        exp_t e;
        int   opc, len, nb, off, base;
        bit   legal;
        opc   = int'(cmd[4:0]);
        len   = int'(cmd[15:8]);
        nb    = (len + 1) << cmd[7:5];
        off   = int'(dst % NBYTES);
        legal = (dst < AW'(MEMB)) && (off + nb <= int'(NBYTES));
        base  = legal ? int'(dst) : 0;
        e.cmd        = '0;
        e.cmd[7:5]   = cmd[7:5];
        e.cmd[15:8]  = cmd[15:8];
        e.dst        = src;
        e.src        = dst;
        e.data       = '0;
        case (opc)
            1: begin
                e.cmd[4:0] = 5'h02;
                if (legal) for (int b = 0; b < nb; b++) e.data[b*8 +: 8] = mem_m[base + b];
                else e.cmd[26:25] = 2'b11;
                expq.push_back(e);
            end
            3: begin
                e.cmd[4:0] = 5'h04;
                if (legal) for (int b = 0; b < nb; b++) mem_m[base + b] = data[b*8 +: 8];
                else e.cmd[26:25] = 2'b11;
                expq.push_back(e);
            end
            5: begin
                if (legal) for (int b = 0; b < nb; b++) mem_m[base + b] = data[b*8 +: 8];
            end
            default: begin
                e.cmd[4:0]   = 5'h04;
                e.cmd[26:25] = 2'b10;
                expq.push_back(e);
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge (or the budget).
    task automatic try_issue(input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                             input logic [DW-1:0] data, input int max_cyc, output bit ok);
        logic [AW-1:0] src;
        src = {$urandom(), $urandom()};
        udev.req_valid   = 1'b1;
        udev.req_cmd     = cmd;
        udev.req_dstaddr = dst;
        udev.req_srcaddr = src;
        udev.req_data    = data;
        ok = 1'b0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(negedge clk);
            if (udev.req_ready) begin
                model_accept(cmd, dst, src, data);
                ok = 1'b1;
            end
            step();
        end
        udev.req_valid = 1'b0;
    endtask

    task automatic issue(input logic [CW-1:0] cmd, input logic [AW-1:0] dst, input logic [DW-1:0] data);
        bit ok;
        try_issue(cmd, dst, data, 50, ok);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout cmd=%h dst=%h", cmd, dst);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((expq.size() != 0 || udev.resp_valid) && c < 300) begin
            step();
            c++;
        end
        if (c >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d", expq.size());
        end
    endtask

    initial begin
        bit ok;
        int acc;
        udev.req_valid   = 1'b0;
        udev.req_cmd     = '0;
        udev.req_dstaddr = '0;
        udev.req_srcaddr = '0;
        udev.req_data    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", udev.req_ready, 1'b0);
        check("rst_resp_valid", udev.resp_valid, 1'b0);
        check("rst_resp_cmd", udev.resp_cmd, '0);
        check("rst_resp_data", udev.resp_data, '0);
        step();
        rst = 1'b0;
        step();

        for (int w = 0; w < int'(REGION_W); w++) issue(mk_cmd(3, 5, 0), AW'(w * NBYTES), rand_data());

        // Aligned write immediately followed by a read of the same bytes.
        issue(mk_cmd(3, 3, 0), 64'h40, DW'(64'h1122334455667788));
        issue(mk_cmd(1, 3, 0), 64'h40, '0);

        issue(mk_cmd(3, 0, 1), 64'h23, DW'(16'hAABB));
        issue(mk_cmd(1, 3, 0), 64'h20, '0);

        issue(mk_cmd(1, 3, 0), AW'(MEMB), '0);
        issue(mk_cmd(7, 3, 0), 64'h40, rand_data());
        issue(mk_cmd(3, 3, 0), AW'(MEMB), rand_data());
        issue(mk_cmd(5, 0, 0), AW'(MEMB + 8), rand_data());
        issue(mk_cmd(1, 3, 3), 64'h08, '0);
        issue(mk_cmd(1, 5, 0), 64'h40, '0);
        drain();

        // Request-to-valid latency with an empty FIFO.
        issue(mk_cmd(1, 2, 0), 64'h44, '0);
        @(negedge clk);
        check("lat_n1_valid", udev.resp_valid, 1'b0);
        @(negedge clk);
        check("lat_n2_valid", udev.resp_valid, 1'b1);
        step();
        drain();

        // Backpressure: FIFO fills, then a legal posted write still goes in.
        ready_mode = 0;
        step();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            try_issue(mk_cmd(1, 3, 0), AW'(128 + 8 * i), '0, 4, ok);
            if (!ok) break;
            acc++;
        end
        check("bp_accepted", acc, 4);
        udev.req_cmd     = mk_cmd(1, 3, 0);
        udev.req_dstaddr = 64'h80;
        @(negedge clk);
        check("bp_ready_low", udev.req_ready, 1'b0);
        step();
        try_issue(mk_cmd(5, 0, 0), 64'h10, DW'(8'h5A), 1, ok);
        check("posted_when_full", ok, 1'b1);
        ready_mode = 1;
        for (int i = acc; i < 8; i++) issue(mk_cmd(1, 3, 0), AW'(128 + 8 * i), '0);
        issue(mk_cmd(1, 0, 0), 64'h10, '0);
        drain();

        // Random traffic under random response backpressure.
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            int r, opc, size, len;
            logic [AW-1:0] dst;
            r    = int'($urandom_range(0, 15));
            opc  = (r < 6) ? 1 : (r < 11) ? 3 : (r < 14) ? 5 : (r == 14) ? 7 : 0;
            size = int'($urandom_range(0, 5));
            len  = int'($urandom_range(0, (32 >> size) - 1));
            dst  = AW'($urandom_range(0, REGION_W - 1) * NBYTES + $urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 19) == 0) dst = AW'(MEMB + $urandom_range(0, 255));
            issue(mk_cmd(opc, size, len), dst, rand_data());
            if ($urandom_range(0, 7) == 0) step();
        end
        ready_mode = 1;
        drain();

        // Reset with two responses waiting in the FIFO.
        ready_mode = 0;
        step();
        issue(mk_cmd(1, 3, 0), 64'h40, '0);
        issue(mk_cmd(1, 3, 0), 64'h48, '0);
        repeat (3) step();
        @(negedge clk);
        check("pre_rst_valid", udev.resp_valid, 1'b1);
        step();
        rst = 1'b1;
        expq.delete();
        @(negedge clk);
        check("in_rst_ready", udev.req_ready, 1'b0);
        step();
        rst = 1'b0;
        ready_mode = 1;
        @(negedge clk);
        check("post_rst_valid", udev.resp_valid, 1'b0);
        repeat (3) step();
        @(negedge clk);
        check("post_rst_idle", udev.resp_valid, 1'b0);
        step();
        issue(mk_cmd(1, 5, 0), 64'h40, '0);
        issue(mk_cmd(1, 5, 0), 64'h00, '0);
        drain();

        check("final_queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
